// File: rtl/xc_aessub_arb.sv
// Two-requester arbiter in front of a shared AES SubBytes unit.
// Issue is combinational (zero added latency); a multi-cycle unit holds the grant in BUSY.
module xc_aessub_arb #(
   parameter bit FAIR = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        flush,
   input  logic [31:0] flush_data,
   input  logic        req_valid_0,
   input  logic        req_valid_1,
   input  logic [31:0] req_rs1_0,
   input  logic [31:0] req_rs1_1,
   input  logic [31:0] req_rs2_0,
   input  logic [31:0] req_rs2_1,
   input  logic        req_enc_0,
   input  logic        req_enc_1,
   input  logic        req_rot_0,
   input  logic        req_rot_1,
   output logic        req_ready_0,
   output logic        req_ready_1,
   output logic [31:0] req_result_0,
   output logic [31:0] req_result_1,
   output logic        sub_flush,
   output logic [31:0] sub_flush_data,
   output logic        sub_valid,
   output logic [31:0] sub_rs1,
   output logic [31:0] sub_rs2,
   output logic        sub_enc,
   output logic        sub_rot,
   input  logic        sub_ready,
   input  logic [31:0] sub_result
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state_reg;
   logic        g_reg;
   logic        p_reg;

   logic [1:0]  valid_vec;
   logic [31:0] rs1_vec [2];
   logic [31:0] rs2_vec [2];
   logic [1:0]  enc_vec;
   logic [1:0]  rot_vec;
   logic [1:0]  ready_vec;
   logic [31:0] result_vec [2];

   logic        win;
   logic        have_win;
   logic        abort;
   logic        complete;

   assign valid_vec  = {req_valid_1, req_valid_0};
   assign rs1_vec[0] = req_rs1_0;
   assign rs1_vec[1] = req_rs1_1;
   assign rs2_vec[0] = req_rs2_0;
   assign rs2_vec[1] = req_rs2_1;
   assign enc_vec    = {req_enc_1, req_enc_0};
   assign rot_vec    = {req_rot_1, req_rot_0};

   // In BUSY the grant is locked; in IDLE pick the winner the same cycle.
   always_comb begin
      have_win = 1'b0;
      win      = 1'b0;
      if (state_reg == BUSY) begin
         have_win = 1'b1;
         win      = g_reg;
      end else begin
         have_win = |valid_vec;
         if (&valid_vec)
            win = FAIR ? ~p_reg : 1'b0;
         else
            win = valid_vec[1];
      end
   end

   // Requester withdrew while its operation was in flight.
   assign abort     = (state_reg == BUSY) && !valid_vec[g_reg];
   assign sub_valid = have_win & ~reset & ~flush & ~abort;
   assign complete  = sub_valid & sub_ready;

   assign sub_rs1        = rs1_vec[win] & {32{sub_valid}};
   assign sub_rs2        = rs2_vec[win] & {32{sub_valid}};
   assign sub_enc        = enc_vec[win] & sub_valid;
   assign sub_rot        = rot_vec[win] & sub_valid;
   assign sub_flush      = reset | flush | abort;
   assign sub_flush_data = flush_data;

   // Result is steered only to the requester being completed; the other sees zero.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_resp
         localparam logic IDX = 1'(gi);
         assign ready_vec[gi]  = complete && (win == IDX);
         assign result_vec[gi] = ready_vec[gi] ? sub_result : 32'h0;
      end
   endgenerate

   assign req_ready_0  = ready_vec[0];
   assign req_ready_1  = ready_vec[1];
   assign req_result_0 = result_vec[0];
   assign req_result_1 = result_vec[1];

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= IDLE;
         g_reg     <= 1'b0;
         p_reg     <= 1'b1;
      end else if (flush || abort) begin
         state_reg <= IDLE;
      end else if (complete) begin
         state_reg <= IDLE;
         p_reg     <= win;
      end else if (state_reg == IDLE && sub_valid) begin
         state_reg <= BUSY;
         g_reg     <= win;
      end
   end

endmodule

// File: tb/tb_xc_aessub_arb.sv
// Directed bench for xc_aessub_arb: stimulus pushes expected completions into a
// scoreboard queue, a negedge monitor pops and compares on every req_ready pulse.
module tb_xc_aessub_arb;

   logic        clock = 1'b0;
   logic        reset;
   logic        flush;
   logic [31:0] flush_data;
   logic        req_valid_0, req_valid_1;
   logic [31:0] req_rs1_0, req_rs1_1, req_rs2_0, req_rs2_1;
   logic        req_enc_0, req_enc_1, req_rot_0, req_rot_1;
   logic        req_ready_0, req_ready_1;
   logic [31:0] req_result_0, req_result_1;
   logic        sub_flush, sub_valid, sub_enc, sub_rot, sub_ready;
   logic [31:0] sub_flush_data, sub_rs1, sub_rs2, sub_result;

   logic        fp_ready_0, fp_ready_1, fp_flush, fp_valid, fp_enc, fp_rot;
   logic [31:0] fp_result_0, fp_result_1, fp_flush_data, fp_rs1, fp_rs2, fp_sub_result;

   logic        mode4;
   logic [1:0]  cnt;
   logic        fp_en;
   int          fp0, fp1;
   int          total, bad;

   typedef struct packed {
      logic        idx;
      logic [31:0] res;
   } exp_t;
   exp_t sb_q[$];

   always #5 clock = ~clock;

   xc_aessub_arb #(.FAIR(1'b1)) dut (
      .clock(clock), .reset(reset), .flush(flush), .flush_data(flush_data),
      .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
      .req_rs1_0(req_rs1_0), .req_rs1_1(req_rs1_1),
      .req_rs2_0(req_rs2_0), .req_rs2_1(req_rs2_1),
      .req_enc_0(req_enc_0), .req_enc_1(req_enc_1),
      .req_rot_0(req_rot_0), .req_rot_1(req_rot_1),
      .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
      .req_result_0(req_result_0), .req_result_1(req_result_1),
      .sub_flush(sub_flush), .sub_flush_data(sub_flush_data),
      .sub_valid(sub_valid), .sub_rs1(sub_rs1), .sub_rs2(sub_rs2),
      .sub_enc(sub_enc), .sub_rot(sub_rot),
      .sub_ready(sub_ready), .sub_result(sub_result)
   );

   xc_aessub_arb #(.FAIR(1'b0)) dut_fp (
      .clock(clock), .reset(reset), .flush(flush), .flush_data(flush_data),
      .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
      .req_rs1_0(req_rs1_0), .req_rs1_1(req_rs1_1),
      .req_rs2_0(req_rs2_0), .req_rs2_1(req_rs2_1),
      .req_enc_0(req_enc_0), .req_enc_1(req_enc_1),
      .req_rot_0(req_rot_0), .req_rot_1(req_rot_1),
      .req_ready_0(fp_ready_0), .req_ready_1(fp_ready_1),
      .req_result_0(fp_result_0), .req_result_1(fp_result_1),
      .sub_flush(fp_flush), .sub_flush_data(fp_flush_data),
      .sub_valid(fp_valid), .sub_rs1(fp_rs1), .sub_rs2(fp_rs2),
      .sub_enc(fp_enc), .sub_rot(fp_rot),
      .sub_ready(fp_valid), .sub_result(fp_sub_result)
   );

   // Unit model: single-cycle, or 4-cycle when mode4 is set.
   assign sub_ready     = mode4 ? (sub_valid && cnt == 2'd3) : sub_valid;
   assign sub_result    = sub_rs1 ^ sub_rs2 ^ 32'h63636363;
   assign fp_sub_result = fp_rs1 ^ fp_rs2 ^ 32'h63636363;

   always @(posedge clock) begin
      if (!sub_valid || sub_ready) cnt <= 2'd0;
      else                         cnt <= cnt + 2'd1;
   end

   // Monitor
   logic [1:0]  mon_rdy;
   logic [31:0] mon_res [2];
   assign mon_rdy    = {req_ready_1, req_ready_0};
   assign mon_res[0] = req_result_0;
   assign mon_res[1] = req_result_1;

   always @(negedge clock) begin
      exp_t e;
      for (int r = 0; r < 2; r++) begin
         total++;
         if (mon_rdy[r]) begin
            if (sb_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_ready r=%0d result=%h required no completion", r, mon_res[r]);
            end else begin
               e = sb_q.pop_front();
               if (e.idx != r[0] || e.res != mon_res[r]) begin
                  bad++;
                  $display("FAIL completion got r=%0d result=%h required r=%0d result=%h",
                           r, mon_res[r], e.idx, e.res);
               end else begin
                  $display("txn r=%0d result=%h @%0t", r, mon_res[r], $time);
               end
            end
         end else if (mon_res[r] != 32'h0) begin
            bad++;
            $display("FAIL result_leak r=%0d got=%h required=00000000", r, mon_res[r]);
         end
      end
      if (fp_en) begin
         fp0 += int'(fp_ready_0);
         fp1 += int'(fp_ready_1);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s got=%h required=%h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic idx, input logic [31:0] res);
      exp_t e;
      e.idx = idx;
      e.res = res;
      sb_q.push_back(e);
   endtask

   initial begin
      total = 0; bad = 0; fp0 = 0; fp1 = 0; fp_en = 1'b0;
      reset = 1'b1; flush = 1'b0; flush_data = '0; mode4 = 1'b0;
      req_valid_0 = 1'b1; req_valid_1 = 1'b1;
      req_rs1_0 = '0; req_rs1_1 = '0; req_rs2_0 = '0; req_rs2_1 = '0;
      req_enc_0 = 1'b1; req_enc_1 = 1'b1; req_rot_0 = 1'b0; req_rot_1 = 1'b0;

      // Reset with requests pending
      @(negedge clock);
      chk("reset_sub_flush", 32'(sub_flush), 32'h1);
      chk("reset_sub_valid", 32'(sub_valid), 32'h0);
      chk("reset_sub_rs1", sub_rs1, 32'h0);
      tick(); tick();

      // Single-cycle unit, both valid: 0,1,0,1
      reset = 1'b0;
      push(1'b0, 32'h63636363); push(1'b1, 32'h63636363);
      push(1'b0, 32'h63636363); push(1'b1, 32'h63636363);
      @(negedge clock);
      chk("c0_sub_enc", 32'(sub_enc), 32'h1);
      chk("c0_sub_flush", 32'(sub_flush), 32'h0);
      for (int i = 0; i < 4; i++) tick();
      req_valid_0 = 1'b0; req_valid_1 = 1'b0;
      tick();

      // Distinct operands, operand muxing and gating
      req_rs1_0 = 32'h11111111; req_rs1_1 = 32'h22222222;
      req_enc_1 = 1'b0; req_rot_1 = 1'b1;
      req_valid_0 = 1'b1; req_valid_1 = 1'b1;
      push(1'b0, 32'h72727272); push(1'b1, 32'h41414141);
      @(negedge clock);
      chk("mux0_rs1", sub_rs1, 32'h11111111);
      chk("mux0_rot", 32'(sub_rot), 32'h0);
      chk("mux0_enc", 32'(sub_enc), 32'h1);
      tick();
      @(negedge clock);
      chk("mux1_rs1", sub_rs1, 32'h22222222);
      chk("mux1_rot", 32'(sub_rot), 32'h1);
      chk("mux1_enc", 32'(sub_enc), 32'h0);
      tick();
      req_valid_0 = 1'b0; req_valid_1 = 1'b0; req_rot_1 = 1'b0;
      @(negedge clock);
      chk("idle_rs1_zero", sub_rs1, 32'h0);
      tick();

      // 4-cycle unit, requester 1 only
      mode4 = 1'b1;
      req_rs1_1 = 32'hDEADBEEF; req_valid_1 = 1'b1;
      push(1'b1, 32'hBDCEDD8C);
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk($sformatf("multi_valid_c%0d", i), 32'(sub_valid), 32'h1);
         chk($sformatf("multi_rs1_c%0d", i), sub_rs1, 32'hDEADBEEF);
         tick();
      end
      req_valid_1 = 1'b0;
      @(negedge clock);
      chk("multi_after_valid", 32'(sub_valid), 32'h0);
      tick();

      // Abort: requester 0 withdraws in the third cycle
      req_rs1_1 = 32'h22222222;
      req_valid_0 = 1'b1;
      tick(); tick();
      req_valid_0 = 1'b0;
      @(negedge clock);
      chk("abort_sub_flush", 32'(sub_flush), 32'h1);
      chk("abort_sub_valid", 32'(sub_valid), 32'h0);
      tick();
      mode4 = 1'b0; req_valid_0 = 1'b1; req_valid_1 = 1'b1;
      push(1'b0, 32'h72727272);
      @(negedge clock);
      chk("post_abort_flush", 32'(sub_flush), 32'h0);
      tick();
      req_valid_0 = 1'b0; req_valid_1 = 1'b0;
      tick();

      // Flush mid-BUSY
      mode4 = 1'b1; req_valid_1 = 1'b1;
      tick();
      flush = 1'b1; flush_data = 32'hA5A5A5A5;
      @(negedge clock);
      chk("flush_sub_flush", 32'(sub_flush), 32'h1);
      chk("flush_data", sub_flush_data, 32'hA5A5A5A5);
      chk("flush_sub_valid", 32'(sub_valid), 32'h0);
      tick();
      flush = 1'b0; flush_data = '0; mode4 = 1'b0;
      req_valid_1 = 1'b0; req_valid_0 = 1'b1;
      push(1'b0, 32'h72727272);
      @(negedge clock);
      chk("post_flush_valid", 32'(sub_valid), 32'h1);
      tick();
      req_valid_0 = 1'b0;
      tick();

      // Reset while BUSY
      mode4 = 1'b1; req_valid_1 = 1'b1;
      tick(); tick();
      reset = 1'b1;
      @(negedge clock);
      chk("busy_reset_flush", 32'(sub_flush), 32'h1);
      chk("busy_reset_valid", 32'(sub_valid), 32'h0);
      chk("busy_reset_rs1", sub_rs1, 32'h0);
      tick();
      reset = 1'b0; mode4 = 1'b0; req_valid_0 = 1'b1; req_valid_1 = 1'b1;
      push(1'b0, 32'h72727272);
      tick();
      req_valid_0 = 1'b0; req_valid_1 = 1'b0;
      tick();

      // Six contended ops: fair instance alternates, fixed-priority instance serves 0 only
      req_valid_0 = 1'b1; req_valid_1 = 1'b1; fp_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push(1'b1, 32'h41414141);
         push(1'b0, 32'h72727272);
      end
      for (int i = 0; i < 6; i++) tick();
      req_valid_0 = 1'b0; req_valid_1 = 1'b0; fp_en = 1'b0;
      tick(); tick();
      chk("fixed_prio_served0", 32'(fp0), 32'd6);
      chk("fixed_prio_served1", 32'(fp1), 32'd0);
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
